solve_scheduler: RTL and testbench

SOLVE_SCHEDULER -- requirements
Module: solve_scheduler

---
 rtl/klotski_pkg.sv | 18 +
 rtl/step_watchdog.sv | 30 +++
 rtl/solve_scheduler.sv | 144 ++++++++++++++
 tb/tb_solve_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/klotski_pkg.sv
// Shared board/mask/target types for the Klotski solver blocks (MoveNum and solve_scheduler).
package klotski_pkg;

   localparam int NUM_TILES = 15;

   typedef logic [3:0]             tile_t;
   typedef logic [3:0][3:0][3:0]   board_t;   // [row][col] -> tile, 0 = blank
   typedef logic [3:0][3:0]        mask_t;    // [row][col] -> cell is final
   typedef logic [1:0][1:0]        target_t;  // {row, col}

   // Tile n lives at row (n-1)/4, column (n-1)%4 in the solved board.
   function automatic target_t tile_target(input tile_t n);
      tile_t idx;
      idx = n - 4'd1;
      return {idx[3:2], idx[1:0]};
   endfunction

endpackage

// File: rtl/step_watchdog.sv
// Per-step cycle counter; flags the cycle in which the count would reach TIMEOUT_CYCLES.
module step_watchdog #(
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int          W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] MAX   = W'(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && count != MAX)
         count <= count + 1'b1;
   end

   // The increment taken this cycle brings the count to TIMEOUT_CYCLES.
   assign expired = enable && (count >= LIMIT);

endmodule

// File: rtl/solve_scheduler.sv
// Sequences MoveNum over tiles 1..NUM_STEPS, skipping tiles already home and guarding each step.
module solve_scheduler
   import klotski_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4095,
   parameter int NUM_STEPS      = 15
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  board_t     i_klotski,
   output logic       o_mv_start,
   output board_t     o_mv_klotski,
   output mask_t      o_mv_mask,
   output target_t    o_mv_target,
   output logic [3:0] o_mv_number,
   input  board_t     i_mv_klotski,
   input  logic       i_mv_finished,
   output board_t     o_klotski,
   output logic [3:0] o_step,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_ERROR} state_t;

   localparam logic [3:0] STEP_LAST = 4'(NUM_STEPS - 1);

   state_t     state, state_nxt;
   board_t     board;
   mask_t      mask;
   logic [3:0] step;
   logic [3:0] number;
   target_t    target;
   logic       placed, last;
   logic       load_start, load_mv, advance, mark, step_inc, mv_start;
   logic       wd_clear, wd_en, wd_expired;

   assign number = step + 4'd1;
   assign target = tile_target(number);
   assign placed = (board[target[1]][target[0]] == number);
   assign last   = (step == STEP_LAST);

   step_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .clear   (wd_clear),
      .enable  (wd_en),
      .expired (wd_expired)
   );

   always_comb begin
      state_nxt  = state;
      load_start = 1'b0;
      load_mv    = 1'b0;
      advance    = 1'b0;
      mark       = 1'b0;
      step_inc   = 1'b0;
      mv_start   = 1'b0;
      wd_clear   = 1'b0;
      wd_en      = 1'b0;
      case (state)
         S_IDLE, S_ERROR: begin
            if (i_start) begin
               load_start = 1'b1;
               state_nxt  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (placed) begin
               advance = 1'b1;
            end else begin
               mv_start  = 1'b1;
               wd_clear  = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            wd_en = 1'b1;
            // A finish arriving in the expiry cycle still counts as success.
            if (i_mv_finished) begin
               load_mv   = 1'b1;
               state_nxt = S_CHECK;
            end else if (wd_expired) begin
               state_nxt = S_ERROR;
            end
         end
         S_CHECK: begin
            if (placed) advance   = 1'b1;
            else        state_nxt = S_ERROR;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      if (advance) begin
         mark = 1'b1;
         if (last) begin
            state_nxt = S_DONE;
         end else begin
            step_inc  = 1'b1;
            state_nxt = S_ISSUE;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         board <= '0;
         mask  <= '0;
         step  <= '0;
      end else begin
         state <= state_nxt;
         if (load_start) begin
            board <= i_klotski;
            mask  <= '0;
            step  <= '0;
         end else if (load_mv) begin
            board <= i_mv_klotski;
         end
         // Once every tile is home the blank cell is settled too.
         if (mark) begin
            if (last) mask <= '1;
            else      mask[target[1]][target[0]] <= 1'b1;
         end
         if (step_inc)
            step <= step + 4'd1;
      end
   end

   assign o_mv_start   = mv_start;
   assign o_mv_klotski = board;
   assign o_mv_mask    = mask;
   assign o_mv_target  = target;
   assign o_mv_number  = number;
   assign o_klotski    = board;
   assign o_step       = step;
   assign o_busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
   assign o_done       = (state == S_DONE);
   assign o_error      = (state == S_ERROR);

endmodule

// File: tb/tb_solve_scheduler.sv
// Table-driven bench for solve_scheduler with a behavioural MoveNum model (20-cycle latency).
module tb_solve_scheduler;
   import klotski_pkg::*;

   localparam int TO = 50;
   localparam logic [63:0] SOLVED = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] SCR    = 64'hA1EC_629F_3754_0B8D;

   logic       clk = 1'b0;
   logic       rst_n, start;
   board_t     klotski;
   logic       mv_start, mv_finished, busy, done, error;
   board_t     mv_klotski_out, mv_klotski_in, o_klotski;
   mask_t      mv_mask;
   target_t    mv_target;
   logic [3:0] mv_number, step;

   logic   model_fin = 1'b0, inj_fin = 1'b0;
   board_t model_brd = '0, inj_brd = '0;
   assign mv_finished   = model_fin | inj_fin;
   assign mv_klotski_in = inj_fin ? inj_brd : model_brd;

   solve_scheduler #(.TIMEOUT_CYCLES(TO), .NUM_STEPS(15)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_klotski(klotski),
      .o_mv_start(mv_start), .o_mv_klotski(mv_klotski_out), .o_mv_mask(mv_mask),
      .o_mv_target(mv_target), .o_mv_number(mv_number), .i_mv_klotski(mv_klotski_in),
      .i_mv_finished(mv_finished), .o_klotski(o_klotski), .o_step(step),
      .o_busy(busy), .o_done(done), .o_error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;
   int mode = 0;   // 0 normal, 1 never finish, 2 unchanged board for tile 4
   int epoch = 0;

   int         pq_num[$];
   int         pq_cyc[$];
   logic [3:0] pq_tgt[$];
   logic [15:0] pq_mask[$];

   function automatic board_t brd(input logic [63:0] h);
      board_t b;
      for (int i = 0; i < 16; i++) b[i/4][i%4] = h[63-4*i -: 4];
      return b;
   endfunction

   // Tile n to its home, blank to n's old cell, displaced tile to the old blank cell.
   function automatic board_t move_tile(input board_t b, input logic [3:0] n);
      int l = 0, z = 0, t;
      board_t r = b;
      logic [3:0] x;
      t = int'(n) - 1;
      for (int i = 0; i < 16; i++) begin
         if (b[i/4][i%4] == n)    l = i;
         if (b[i/4][i%4] == 4'd0) z = i;
      end
      x = b[t/4][t%4];
      r[z/4][z%4] = x;
      r[t/4][t%4] = n;
      r[l/4][l%4] = 4'd0;
      return r;
   endfunction

   always begin
      @(negedge clk);
      if (rst_n && mv_start && mode != 1) begin
         int ep;
         board_t res;
         ep  = epoch;
         res = (mode == 2 && mv_number == 4'd4) ? mv_klotski_out : move_tile(mv_klotski_out, mv_number);
         repeat (20) @(posedge clk);
         @(negedge clk);
         if (ep == epoch) begin
            model_brd = res;
            model_fin = 1'b1;
            @(negedge clk);
            model_fin = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && mv_start) begin
         pq_num.push_back(int'(mv_number));
         pq_cyc.push_back(cyc);
         pq_tgt.push_back(mv_target);
         pq_mask.push_back(mv_mask);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] init;
      int          mode;
      logic [15:0] pset;    // bit n set: tile n gets a MoveNum pulse
      bit          exp_err;
      int          exp_step;
      logic [63:0] fin;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v, input int idx);
      int done_c = -1, err_c = -1, base, start_c;
      int expq[$];
      mode = v.mode;
      base = pq_num.size();
      @(negedge clk);
      klotski = brd(v.init);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_c = cyc;
      chk($sformatf("v%0d_err_cleared", idx), error, 0);
      chk($sformatf("v%0d_busy", idx), busy, 1);
      for (int t = 0; t < 3000 && done_c < 0 && err_c < 0; t++) begin
         if (done)       done_c = cyc;
         else if (error) err_c = cyc;
         else            @(negedge clk);
      end
      checks++;
      if (done_c < 0 && err_c < 0) begin
         errors++;
         $display("FAIL v%0d_finish: neither done nor error within cycle budget", idx);
      end
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_error", idx), error, v.exp_err);
      chk($sformatf("v%0d_done_seen", idx), done_c >= 0, !v.exp_err);
      chk($sformatf("v%0d_step", idx), step, v.exp_step);
      chk($sformatf("v%0d_board", idx), o_klotski, brd(v.fin));
      chk($sformatf("v%0d_busy_end", idx), busy, 0);
      if (!v.exp_err) chk($sformatf("v%0d_mask", idx), mv_mask, 16'hFFFF);
      if (v.init == SOLVED && done_c >= 0)
         chk($sformatf("v%0d_latency", idx), done_c - start_c + 1, 16);
      for (int n = 1; n < 16; n++) if (v.pset[n]) expq.push_back(n);
      chk($sformatf("v%0d_pulse_count", idx), pq_num.size() - base, expq.size());
      for (int i = 0; i < expq.size() && base + i < pq_num.size(); i++) begin
         chk($sformatf("v%0d_pulse%0d_num", idx, i), pq_num[base+i], expq[i]);
         chk($sformatf("v%0d_pulse%0d_tgt", idx, i), pq_tgt[base+i],
             {2'((expq[i]-1)/4), 2'((expq[i]-1)%4)});
         chk($sformatf("v%0d_pulse%0d_mask", idx, i), pq_mask[base+i], (64'd1 << (expq[i]-1)) - 1);
      end
      if (v.mode == 1 && err_c >= 0 && pq_num.size() > base)
         chk($sformatf("v%0d_timeout_cycle", idx), err_c - pq_cyc[base], 51);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int base, t;
      vecs[0] = '{SOLVED,                  0, 16'h0000, 1'b0, 14, SOLVED};
      vecs[1] = '{SCR,                     0, 16'hFFFE, 1'b0, 14, SOLVED};
      vecs[2] = '{64'h1234_5678_9ABC_DE0F, 0, 16'h8000, 1'b0, 14, SOLVED};
      vecs[3] = '{64'h1234_5076_9ABC_DEF8, 0, 16'h0140, 1'b0, 14, SOLVED};
      vecs[4] = '{SCR,                     1, 16'h0002, 1'b1, 0,  SCR};
      vecs[5] = '{SCR,                     2, 16'h001E, 1'b1, 3,  64'h123C_6E9F_0754_AB8D};

      rst_n = 1'b0; start = 1'b0; klotski = brd(SCR);
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_mv_start", mv_start, 0);
      chk("rst_board", o_klotski, 0);
      chk("rst_step", step, 0);
      chk("rst_mask", mv_mask, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_latch", o_klotski, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Restart during WAIT is ignored, then an async reset lands mid-WAIT.
      mode = 0;
      base = pq_num.size();
      @(negedge clk);
      klotski = brd(SCR);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (pq_num.size() == base && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("w_first_pulse", pq_num.size() - base, 1);
      repeat (5) @(negedge clk);
      klotski = brd(SOLVED);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("w_no_relatch", o_klotski, brd(SCR));
      chk("w_step", step, 0);
      chk("w_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      epoch++;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_error", error, 0);
      chk("ar_mv_start", mv_start, 0);
      chk("ar_board", o_klotski, 0);
      chk("ar_step", step, 0);
      chk("ar_mask", mv_mask, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("ar_pulses", pq_num.size() - base, 1);
      run_vec(vecs[1], 6);

      // A finish pulse while idle must not touch the board.
      @(negedge clk);
      inj_brd = brd(SCR);
      inj_fin = 1'b1;
      @(negedge clk);
      inj_fin = 1'b0;
      @(negedge clk);
      chk("idle_finish_ignored", o_klotski, brd(SOLVED));
      chk("idle_finish_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
